// File: rtl/morse_pkg.sv
// morse_pkg: shared types and constants for the Morse receiver.
//   - state_e      : decoder FSM states
//   - CODE_S..Z    : 3-bit letter codes, same encoding as the SW[2:0] letter select
//   - DOT_TICKS, DASH_TICKS, GAP_TICKS, MAX_SYMS : timing units (ticks) and symbol limit
//   - lookup_letter: (symbol count, symbol bits) -> {hit, code}
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [2:0] CODE_S = 3'd0;
  localparam logic [2:0] CODE_T = 3'd1;
  localparam logic [2:0] CODE_U = 3'd2;
  localparam logic [2:0] CODE_V = 3'd3;
  localparam logic [2:0] CODE_W = 3'd4;
  localparam logic [2:0] CODE_X = 3'd5;
  localparam logic [2:0] CODE_Y = 3'd6;
  localparam logic [2:0] CODE_Z = 3'd7;

  localparam int DOT_TICKS  = 1;
  localparam int DASH_TICKS = 3;
  localparam int GAP_TICKS  = 3;
  localparam int MAX_SYMS   = 4;

  // Symbols are stored newest-at-LSB, 1 = dash. Unused upper bits stay 0
  // because the store is cleared at the start of every letter.
  function automatic logic [3:0] lookup_letter(input logic [2:0] len, input logic [3:0] sym);
    logic [3:0] res;
    res = {1'b0, CODE_S};
    case ({len, sym})
      {3'd3, 4'b0000}: res = {1'b1, CODE_S};
      {3'd1, 4'b0001}: res = {1'b1, CODE_T};
      {3'd3, 4'b0001}: res = {1'b1, CODE_U};
      {3'd4, 4'b0001}: res = {1'b1, CODE_V};
      {3'd3, 4'b0011}: res = {1'b1, CODE_W};
      {3'd4, 4'b1001}: res = {1'b1, CODE_X};
      {3'd4, 4'b1011}: res = {1'b1, CODE_Y};
      {3'd4, 4'b1100}: res = {1'b1, CODE_Z};
      default:         res = {1'b0, CODE_S};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rate_tick.sv
// rate_tick: sampling-rate divider for the Morse receiver.
//   Counts 0..TICK_DIV and wraps; tick is high for the one cycle whose count wraps.
//   reload forces the count to TICK_DIV/2 so the next tick lands mid-bit.
// Ports:
//   CLOCK_50 in  system clock
//   reset    in  synchronous active-high reset (count -> 0)
//   reload   in  phase realign request
//   tick     out one-cycle sample strobe
module rate_tick #(
  parameter int TICK_DIV = 25,
  parameter int CNT_W    = 26
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic reload,
  output logic tick
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(TICK_DIV / 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == TERM) cnt_d = '0;
    if (reload)        cnt_d = HALF;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == TERM);

endmodule

// File: rtl/morse_decoder.sv
// morse_decoder: receives a Morse level stream (one bit per tick) and decodes S..Z.
// Ports:
//   CLOCK_50    in  system clock
//   reset       in  synchronous active-high reset
//   morse_in    in  raw Morse level, 1 = mark, asynchronous to the tick
//   letter_code out last decoded letter (S=000 .. Z=111), 000 on error
//   valid       out one-cycle strobe when letter_code/err update
//   err         out last letter malformed or unknown
//   busy        out FSM not idle
// Build option: define MORSE_MIDSAMPLE_EN to realign the divider to bit centre
// on every edge of the synchronised input; otherwise the divider free-runs.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int TICK_DIV = 25,
  parameter int CNT_W    = 26
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       morse_in,
  output logic [2:0] letter_code,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  localparam logic [2:0] DOT_RUN  = 3'(DOT_TICKS);
  localparam logic [2:0] DASH_RUN = 3'(DASH_TICKS);
  localparam logic [2:0] GAP_RUN  = 3'(GAP_TICKS);
  localparam logic [2:0] MAX_LEN  = 3'(MAX_SYMS);
  localparam logic [2:0] RUN_MAX  = 3'd7;

  logic       ms_meta_q, ms_q;
  logic       tick, reload;

  state_e     state_q, state_d;
  logic [2:0] run_q, run_d;
  logic [3:0] sym_q, sym_d;
  logic [2:0] sym_len_q, sym_len_d;
  logic       bad_q, bad_d;
  logic [2:0] letter_code_q, letter_code_d;
  logic       err_q, err_d;
  logic       valid_q, valid_d;
  logic [3:0] lk;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ms_meta_q <= 1'b0;
      ms_q      <= 1'b0;
    end else begin
      ms_meta_q <= morse_in;
      ms_q      <= ms_meta_q;
    end
  end

`ifdef MORSE_MIDSAMPLE_EN
  logic ms_prev_q;
  always_ff @(posedge CLOCK_50) begin
    if (reset) ms_prev_q <= 1'b0;
    else       ms_prev_q <= ms_q;
  end
  assign reload = ms_q ^ ms_prev_q;
`else
  assign reload = 1'b0;
`endif

  rate_tick #(
    .TICK_DIV(TICK_DIV),
    .CNT_W   (CNT_W)
  ) u_rate_tick (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .reload  (reload),
    .tick    (tick)
  );

  assign lk = lookup_letter(sym_len_q, sym_q);

  always_comb begin
    state_d       = state_q;
    run_d         = run_q;
    sym_d         = sym_q;
    sym_len_d     = sym_len_q;
    bad_d         = bad_q;
    letter_code_d = letter_code_q;
    err_d         = err_q;
    valid_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick && ms_q) begin
          state_d   = ST_MARK;
          run_d     = 3'd1;
          sym_d     = 4'd0;
          sym_len_d = 3'd0;
          bad_d     = 1'b0;
        end
      end
      ST_MARK: begin
        if (tick) begin
          if (ms_q) begin
            // Longer than a dash can ever be: letter is already malformed.
            if (run_q >= DASH_RUN) bad_d = 1'b1;
            if (run_q != RUN_MAX)  run_d = run_q + 3'd1;
          end else begin
            if (run_q != DOT_RUN && run_q != DASH_RUN) bad_d = 1'b1;
            if (sym_len_q == MAX_LEN) begin
              bad_d = 1'b1;
            end else begin
              sym_d     = {sym_q[2:0], (run_q == DASH_RUN)};
              sym_len_d = sym_len_q + 3'd1;
            end
            state_d = ST_SPACE;
            run_d   = 3'd1;
          end
        end
      end
      ST_SPACE: begin
        if (tick) begin
          if (!ms_q) begin
            run_d = run_q + 3'd1;
            if (run_q + 3'd1 == GAP_RUN) state_d = ST_DONE;
          end else begin
            // Too long for an intra-letter gap, too short for a letter end.
            if (run_q == GAP_RUN - 3'd1) bad_d = 1'b1;
            state_d = ST_MARK;
            run_d   = 3'd1;
          end
        end
      end
      ST_DONE: begin
        valid_d = 1'b1;
        state_d = ST_IDLE;
        if (bad_q || !lk[3]) begin
          err_d         = 1'b1;
          letter_code_d = CODE_S;
        end else begin
          err_d         = 1'b0;
          letter_code_d = lk[2:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      run_q         <= 3'd0;
      sym_q         <= 4'd0;
      sym_len_q     <= 3'd0;
      bad_q         <= 1'b0;
      letter_code_q <= CODE_S;
      err_q         <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      sym_q         <= sym_d;
      sym_len_q     <= sym_len_d;
      bad_q         <= bad_d;
      letter_code_q <= letter_code_d;
      err_q         <= err_d;
      valid_q       <= valid_d;
    end
  end

  assign letter_code = letter_code_q;
  assign err         = err_q;
  assign valid       = valid_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: directed self-checking bench for morse_decoder.
// Each Morse bit is held for one tick period; bit slots start mid-way between
// ticks so the synchronised level is stable when it is sampled.
module tb_morse_decoder;

  localparam int TICK_DIV = 25;
  localparam int SLOT     = TICK_DIV + 1;
`ifdef MORSE_MIDSAMPLE_EN
  localparam int TICK_OFF = 16;  // edge -> 2 sync cycles -> reload -> 13 counts
`else
  localparam int TICK_OFF = 13;  // slots start at count 12, tick at count 25
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       morse_in = 1'b0;
  logic [2:0] letter_code;
  logic       valid, err, busy;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int last_fall = 0;

  logic [2:0] v_code[$];
  logic       v_err[$];
  int         v_cyc[$];

  always #5 clk = ~clk;

  morse_decoder #(.TICK_DIV(TICK_DIV), .CNT_W(26)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .morse_in   (morse_in),
    .letter_code(letter_code),
    .valid      (valid),
    .err        (err),
    .busy       (busy)
  );

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (valid) begin
      v_code.push_back(letter_code);
      v_err.push_back(err);
      v_cyc.push_back(cyc);
      $display("valid cyc=%0d letter_code=%0d err=%0b", cyc, letter_code, err);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] code_at(input int i);
    return (i < v_code.size()) ? 32'(v_code[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] err_at(input int i);
    return (i < v_err.size()) ? 32'(v_err[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] cyc_at(input int i);
    return (i < v_cyc.size()) ? 32'(v_cyc[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic clear_log();
    v_code.delete();
    v_err.delete();
    v_cyc.delete();
  endtask

  // Reset for 3 edges, then advance to count 12 so slots are centred on ticks.
  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    morse_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] v, input int len);
    for (int i = 0; i < len; i++) begin
      if (morse_in && !v[i]) last_fall = cyc;
      morse_in = v[i];
      repeat (SLOT) @(negedge clk);
    end
  endtask

  task automatic send_letter(input logic [31:0] v, input int len);
    send_bits(v, len);
    send_bits(32'd0, 3);
  endtask

  logic [31:0] pat [8];
  int          plen[8];
  logic [31:0] bad_pat [4];
  int          bad_len [4];

  initial begin
    pat[0] = 32'b10101;          plen[0] = 5;   // S
    pat[1] = 32'b111;            plen[1] = 3;   // T
    pat[2] = 32'b1110101;        plen[2] = 7;   // U
    pat[3] = 32'b111010101;      plen[3] = 9;   // V
    pat[4] = 32'b111011101;      plen[4] = 9;   // W
    pat[5] = 32'b11101010111;    plen[5] = 11;  // X
    pat[6] = 32'b1110111010111;  plen[6] = 13;  // Y
    pat[7] = 32'b10101110111;    plen[7] = 11;  // Z
    bad_pat[0] = 32'b11;         bad_len[0] = 2;  // 2-tick mark
    bad_pat[1] = 32'b11111;      bad_len[1] = 5;  // 5-tick mark
    bad_pat[2] = 32'b101010101;  bad_len[2] = 9;  // five dots
    bad_pat[3] = 32'b1001;       bad_len[3] = 4;  // 2-tick intra-letter space

    // Idle after reset: nothing decoded, outputs at reset values.
    do_reset();
    clear_log();
    repeat (494) @(negedge clk);
    check_val("idle_valid_count", v_code.size(), 0);
    check_val("idle_code", letter_code, 3'd0);
    check_val("idle_err", err, 1'b0);
    check_val("idle_busy", busy, 1'b0);

    // Single S with exact latency.
    do_reset();
    clear_log();
    send_letter(pat[0], plen[0]);
    send_bits(32'd0, 1);
    check_val("s_count", v_code.size(), 1);
    check_val("s_code", code_at(0), 3'd0);
    check_val("s_err", err_at(0), 1'b0);
    check_val("s_latency_cyc", cyc_at(0), last_fall + 2 * SLOT + TICK_OFF + 2);

    // S..Z back-to-back.
    do_reset();
    clear_log();
    for (int i = 0; i < 8; i++) send_letter(pat[i], plen[i]);
    send_bits(32'd0, 1);
    check_val("all_count", v_code.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("all_code_%0d", i), code_at(i), i);
      check_val($sformatf("all_err_%0d", i), err_at(i), 1'b0);
    end

    // Malformed letters, each preceded by a good T so the code/err change is visible.
    for (int k = 0; k < 4; k++) begin
      do_reset();
      clear_log();
      send_letter(pat[1], plen[1]);
      send_letter(bad_pat[k], bad_len[k]);
      send_bits(32'd0, 1);
      check_val($sformatf("bad%0d_count", k), v_code.size(), 2);
      check_val($sformatf("bad%0d_pre_code", k), code_at(0), 3'd1);
      check_val($sformatf("bad%0d_code", k), code_at(1), 3'd0);
      check_val($sformatf("bad%0d_err", k), err_at(1), 1'b1);
    end

    // Reset mid-letter discards the partial letter.
    do_reset();
    clear_log();
    send_bits(32'b0101, 4);
    check_val("mid_busy", busy, 1'b1);
    do_reset();
    check_val("mid_busy_after_reset", busy, 1'b0);
    send_letter(pat[1], plen[1]);
    send_bits(32'd0, 1);
    check_val("mid_count", v_code.size(), 1);
    check_val("mid_code", code_at(0), 3'd1);
    check_val("mid_err", err_at(0), 1'b0);

`ifdef MORSE_MIDSAMPLE_EN
    // T with a 13-cycle phase offset: drive changes land right on the free-run tick.
    do_reset();
    repeat (13) @(negedge clk);
    clear_log();
    send_letter(pat[1], plen[1]);
    send_bits(32'd0, 1);
    check_val("phase_count", v_code.size(), 1);
    check_val("phase_code", code_at(0), 3'd1);
    check_val("phase_err", err_at(0), 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/morse_decoder.md
Name: morse_decoder

Overview:
- Receiver side of the lab Morse link. Samples a serial Morse level stream, one bit per tick, and decodes letters S..Z.
- Outputs the 3-bit letter code, using the same encoding as the SW[2:0] letter select: S=000, T=001, U=010, V=011, W=100, X=101, Y=110, Z=111.
- Sits after the Morse shift-out path, or after a KEY input. Drives LEDR / HEX display logic.

Parameters:
- TICK_DIV, 25, terminal count of the rate divider. A tick occurs every TICK_DIV+1 cycles. Use 25 for simulation; 24999999 gives 2 Hz at 50 MHz.
- CNT_W, 26, width of the rate divider counter.

Ports:
- CLOCK_50  input  1  system clock. Single clock domain.
- reset  input  1  synchronous, active-high reset.
- morse_in  input  1  raw Morse level (1 = mark). Asynchronous to the tick.
- letter_code  output  3  last decoded letter code.
- valid  output  1  one-cycle strobe: letter_code and err have been updated.
- err  output  1  last letter was malformed or unknown.
- busy  output  1  FSM is not in IDLE.

Behaviour:
- Reset: synchronous, active-high, checked at posedge CLOCK_50. Clears the divider, FSM (→ IDLE), run counter, symbol register, symbol count and bad flag. Outputs after reset: letter_code=000, valid=0, err=0, busy=0. Reset mid-letter discards the partial letter with no valid pulse.
- Input: morse_in passes through a 2-flop synchroniser; only the synchronised value (ms) is sampled.
- Rate divider: counts 0..TICK_DIV, then wraps to 0. tick=1 for exactly the one cycle in which the count wraps.
- Timing units, all in ticks:
  - dot = 1 mark; dash = 3 marks.
  - intra-letter gap = 1 space.
  - letter end = 3 consecutive spaces.
- Symbol store: sym[3:0] shifts left, with the new symbol entering at the LSB (1 = dash). sym_len[2:0] holds the symbol count.
- FSM states: IDLE, MARK, SPACE, DONE. State changes only on tick cycles, except DONE.
  - IDLE: on tick with ms=1 → MARK, run=1, sym=0, sym_len=0, bad=0. On tick with ms=0, stay in IDLE.
  - MARK, tick with ms=1: run increments, saturating at 7. If run would exceed 3, set bad.
  - MARK, tick with ms=0: classify the mark. run==1 → dot; run==3 → dash; otherwise set bad. Append the symbol; if sym_len is already 4, set bad and do not shift. Go to SPACE with run=1.
  - SPACE, tick with ms=0: run increments. When run reaches 3 → DONE.
  - SPACE, tick with ms=1: if run==2, set bad. Go to MARK with run=1.
  - DONE: lasts one cycle, regardless of tick. Looks up (sym_len, sym) and registers the outputs, then → IDLE.
- Lookup table (sym_len / sym → letter_code):
  - 3 / 000 → S; 1 / 0001 → T; 3 / 001 → U; 4 / 0001 → V.
  - 3 / 011 → W; 4 / 1001 → X; 4 / 1011 → Y; 4 / 1100 → Z.
- Output update on the DONE cycle's edge:
  - valid=1 for exactly one cycle.
  - If bad is set or there is no table match: err=1 and letter_code=000.
  - Otherwise: err=0 and letter_code = the table value.
  - letter_code and err hold their values until the next DONE.
- Latency: valid is asserted 2 cycles after the tick cycle that samples the third consecutive space.
- A mark stuck high keeps the FSM in MARK (run saturated, bad set) until ms falls. There is no timeout.
- busy = (state != IDLE).

Optional Feature:
- MORSE_MIDSAMPLE_EN defined: on every edge of ms, the divider reloads to TICK_DIV/2. Sampling then lands at bit centre, tolerating unaligned transmitter phase.
- Without it: the divider is free-running, and sampling phase is whatever the reset alignment gives.

Decomposition:
- Package morse_pkg holds:
  - the FSM state enum;
  - letter code constants S..Z;
  - DOT_TICKS=1, DASH_TICKS=3, GAP_TICKS=3 and MAX_SYMS=4;
  - the lookup function (len, sym) → {hit, code}.
- Sub-module rate_tick (parameters TICK_DIV, CNT_W; ports CLOCK_50, reset, reload, tick). The decoder instantiates it once.

Test Plan:
- Reset held for 3 cycles, then released with morse_in=0 for 500 cycles → valid stays 0, letter_code=000, err=0, busy=0.
- Tick-aligned stream 10101 followed by 000 (S) → one valid pulse, letter_code=000, err=0, 2 cycles after the third space tick.
- All eight patterns S..Z driven back-to-back with 3-tick gaps, e.g. Y = 1110111010111 sent LSB-first → codes 000..111 in order, 8 valid pulses, err=0 on each.
- Mark of 2 ticks followed by 3 spaces → valid, err=1, letter_code=000. Mark of 5 ticks → same result.
- Five dots separated by 1-tick gaps → err=1. A 2-tick space inside a letter → err=1.
- Reset asserted mid-letter after 2 dots, then T (111 followed by 000) sent → only one valid pulse, letter_code=001. With MORSE_MIDSAMPLE_EN defined, T sent with a 13-cycle phase offset still decodes to 001.
